// File: rtl/robsmult_n.sv
// Robertson sequential multiplier: WIDTH+1 cycles start->done, one add/sub-and-shift per bit; start ignored while busy.
// Define ROBSMULT_UNSIGNED_EN to add the per-operation is_signed input (otherwise always two's complement).
module robsmult_n #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic [WIDTH-1:0]   multiplicand,
`ifdef ROBSMULT_UNSIGNED_EN
   input  logic               is_signed,
`endif
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_y;
   logic [CW-1:0]    r_count;
   logic             r_signed;

   logic             w_mode;
   logic             w_accept;
   logic             w_last;
   logic             w_sub;
   logic [WIDTH:0]   w_a_ext;
   logic [WIDTH:0]   w_add_ext;
   logic [WIDTH:0]   w_sum;

`ifdef ROBSMULT_UNSIGNED_EN
   assign w_mode = is_signed;
`else
   assign w_mode = 1'b1;
`endif

   assign w_last = (r_count == '0);

   // The final step subtracts in signed mode because the multiplier MSB carries negative weight.
   assign w_sub     = r_signed & w_last;
   assign w_a_ext   = {r_signed & r_a[WIDTH-1], r_a};
   assign w_add_ext = r_q[0] ? {r_signed & r_y[WIDTH-1], r_y} : '0;
   assign w_sum     = w_sub ? (w_a_ext - w_add_ext) : (w_a_ext + w_add_ext);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a      <= '0;
         r_q      <= '0;
         r_y      <= '0;
         r_count  <= '0;
         r_signed <= 1'b0;
      end else if (w_accept) begin
         r_a      <= '0;
         r_q      <= multiplier;
         r_y      <= multiplicand;
         r_count  <= CW'(WIDTH - 1);
         r_signed <= w_mode;
      end else if (r_state == S_RUN) begin
         // sum[WIDTH] shifts into A's MSB, keeping the sign correct even on overflow.
         r_a <= w_sum[WIDTH:1];
         r_q <= {w_sum[0], r_q[WIDTH-1:1]};
         if (!w_last) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   assign product = {r_a, r_q};
   assign busy    = (r_state == S_RUN);
   assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_robsmult_n.sv
// Scoreboard bench for robsmult_n at WIDTH 8, 4, 16 and 2 sharing one clock and reset.
// Expected products and start cycles are queued at each accepted start and checked on done.
module tb_robsmult_n;

   logic        clk = 1'b0;
   logic        reset;
   logic        st  [4];
   logic [31:0] opx [4];
   logic [31:0] opy [4];
`ifdef ROBSMULT_UNSIGNED_EN
   logic        sg  [4];
`endif
   logic        bz  [4];
   logic        dn  [4];
   logic [15:0] p8;
   logic [7:0]  p4;
   logic [31:0] p16;
   logic [3:0]  p2;

   int          n_chk  = 0;
   int          n_fail = 0;
   int          cyc    = 0;
   int          bcnt   [4];
   logic [63:0] exp_q  [4][$];
   int          cyc_q  [4][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   robsmult_n #(.WIDTH(8)) u_w8 (
      .clk(clk), .reset(reset), .start(st[0]),
      .multiplier(opx[0][7:0]), .multiplicand(opy[0][7:0]),
`ifdef ROBSMULT_UNSIGNED_EN
      .is_signed(sg[0]),
`endif
      .product(p8), .busy(bz[0]), .done(dn[0]));

   robsmult_n #(.WIDTH(4)) u_w4 (
      .clk(clk), .reset(reset), .start(st[1]),
      .multiplier(opx[1][3:0]), .multiplicand(opy[1][3:0]),
`ifdef ROBSMULT_UNSIGNED_EN
      .is_signed(sg[1]),
`endif
      .product(p4), .busy(bz[1]), .done(dn[1]));

   robsmult_n #(.WIDTH(16)) u_w16 (
      .clk(clk), .reset(reset), .start(st[2]),
      .multiplier(opx[2][15:0]), .multiplicand(opy[2][15:0]),
`ifdef ROBSMULT_UNSIGNED_EN
      .is_signed(sg[2]),
`endif
      .product(p16), .busy(bz[2]), .done(dn[2]));

   robsmult_n #(.WIDTH(2)) u_w2 (
      .clk(clk), .reset(reset), .start(st[3]),
      .multiplier(opx[3][1:0]), .multiplicand(opy[3][1:0]),
`ifdef ROBSMULT_UNSIGNED_EN
      .is_signed(sg[3]),
`endif
      .product(p2), .busy(bz[3]), .done(dn[3]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int wof(input int i);
      case (i)
         0:       return 8;
         1:       return 4;
         2:       return 16;
         default: return 2;
      endcase
   endfunction

   function automatic logic [63:0] get_p(input int i);
      case (i)
         0:       return {48'd0, p8};
         1:       return {56'd0, p4};
         2:       return {32'd0, p16};
         default: return {60'd0, p2};
      endcase
   endfunction

   function automatic logic [63:0] refmul(input int w, input logic [31:0] x, input logic [31:0] y, input bit s);
      logic [31:0] mask;
      longint      a;
      longint      b;
      longint      m;
      logic [63:0] r;
      mask = (32'd1 << w) - 32'd1;
      a = longint'({32'd0, x & mask});
      b = longint'({32'd0, y & mask});
      if (s && x[w-1]) a = a - (longint'(1) << w);
      if (s && y[w-1]) b = b - (longint'(1) << w);
      m = a * b;
      r = m;
      return r & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   // Scoreboard: on every done pop the oldest expectation and verify value, latency and busy length.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (reset) begin
            bcnt[i] = 0;
         end else begin
            if (bz[i]) bcnt[i]++;
            if (dn[i]) begin
               chk($sformatf("busy_done_excl_w%0d", wof(i)), {63'd0, bz[i]}, 64'd0);
               if (exp_q[i].size() == 0) begin
                  chk($sformatf("spurious_done_w%0d", wof(i)), 64'd1, 64'd0);
               end else begin
                  chk($sformatf("product_w%0d", wof(i)), get_p(i), exp_q[i].pop_front());
                  chk($sformatf("latency_w%0d", wof(i)), 64'(cyc - cyc_q[i].pop_front()), 64'(wof(i) + 1));
                  chk($sformatf("busy_len_w%0d", wof(i)), 64'(bcnt[i]), 64'(wof(i)));
               end
               bcnt[i] = 0;
            end
         end
      end
   end

   task automatic start_op(input int i, input logic [31:0] x, input logic [31:0] y, input bit s);
      opx[i] = x;
      opy[i] = y;
`ifdef ROBSMULT_UNSIGNED_EN
      sg[i] = s;
`endif
      st[i] = 1'b1;
      exp_q[i].push_back(refmul(wof(i), x, y, s));
      cyc_q[i].push_back(cyc);
      @(posedge clk);
      #1;
      st[i]  = 1'b0;
      opx[i] = $urandom;
      opy[i] = $urandom;
   endtask

   task automatic wait_done(input int i);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!dn[i] && n < 64);
      if (!dn[i]) chk($sformatf("done_timeout_w%0d", wof(i)), 64'd0, 64'd1);
   endtask

   // Corner operands first, then random pairs, all issued back-to-back.
   task automatic run_set(input int i, input int nrand);
      int          w;
      logic [31:0] mask;
      logic [31:0] sp [5];
      w    = wof(i);
      mask = (32'd1 << w) - 32'd1;
      sp[0] = 32'd0;
      sp[1] = 32'd1;
      sp[2] = mask;
      sp[3] = 32'd1 << (w - 1);
      sp[4] = (32'd1 << (w - 1)) - 32'd1;
      for (int a = 0; a < 5; a++) begin
         for (int b = 0; b < 5; b++) begin
            start_op(i, sp[a], sp[b], 1'b1);
            wait_done(i);
         end
      end
      for (int k = 0; k < nrand; k++) begin
         start_op(i, $urandom & mask, $urandom & mask, 1'b1);
         wait_done(i);
      end
   endtask

   initial begin
      int k1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         st[i]   = 1'b0;
         opx[i]  = '0;
         opy[i]  = '0;
         bcnt[i] = 0;
`ifdef ROBSMULT_UNSIGNED_EN
         sg[i]   = 1'b1;
`endif
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst_product_w%0d", wof(i)), get_p(i), 64'd0);
         chk($sformatf("rst_busy_w%0d", wof(i)), {63'd0, bz[i]}, 64'd0);
         chk($sformatf("rst_done_w%0d", wof(i)), {63'd0, dn[i]}, 64'd0);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;

      start_op(0, 32'd3, 32'hFB, 1'b1);
      wait_done(0);
      chk("x3_ym5", {48'd0, p8}, 64'hFFF1);

      @(posedge clk);
      #1;
      start_op(0, 32'h80, 32'h80, 1'b1);
      wait_done(0);
      chk("min_sq", {48'd0, p8}, 64'h4000);
      k1 = cyc;
      start_op(0, 32'hFF, 32'hFF, 1'b1);
      wait_done(0);
      chk("m1_sq", {48'd0, p8}, 64'h0001);
      chk("b2b_gap", 64'(cyc - k1), 64'd9);

      @(posedge clk);
      #1;
      start_op(0, 32'd7, 32'hF6, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      st[0]  = 1'b1;
      opx[0] = 32'd55;
      opy[0] = 32'd2;
      @(posedge clk);
      #1;
      st[0] = 1'b0;
      wait_done(0);
      chk("midrun_ignored", {48'd0, p8}, 64'hFFBA);

      @(posedge clk);
      #1;
      start_op(0, 32'h5A, 32'h3C, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_product", {48'd0, p8}, 64'd0);
      chk("abort_busy", {63'd0, bz[0]}, 64'd0);
      chk("abort_done", {63'd0, dn[0]}, 64'd0);
      reset = 1'b0;
      exp_q[0].delete();
      cyc_q[0].delete();
      @(posedge clk);
      #1;
      chk("post_abort_idle", {63'd0, bz[0]}, 64'd0);

`ifdef ROBSMULT_UNSIGNED_EN
      start_op(0, 32'hFF, 32'hFF, 1'b0);
      wait_done(0);
      chk("unsigned_ff_sq", {48'd0, p8}, 64'hFE01);
      start_op(0, 32'hFF, 32'hFF, 1'b1);
      wait_done(0);
      chk("signed_ff_sq", {48'd0, p8}, 64'h0001);
`endif

      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            start_op(3, a, b, 1'b1);
            wait_done(3);
         end
      end
      start_op(3, 32'd2, 32'd2, 1'b1);
      wait_done(3);
      chk("w2_m2_sq", {60'd0, p2}, 64'h4);

      run_set(1, 1000);
      run_set(2, 1000);

      repeat (5) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("sb_drained_w%0d", wof(i)), 64'(exp_q[i].size()), 64'd0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
